// File: rtl/dct8_chen_pkg.sv
// Shared constants and arithmetic helpers for the Chen 8-point DCT datapath.
// Cosine values and the output rescale are defined once here so width sweeps stay consistent.
package dct8_chen_pkg;

    localparam int NPT  = 8;
    localparam int HALF = NPT / 2;

    // cos(k*pi/16) for k = 0..7; only evaluated while elaborating constants.
    function automatic real cos_k16(input int k);
        case (k)
            0:       return 1.000000000000000;
            1:       return 0.980785280403230;
            2:       return 0.923879532511287;
            3:       return 0.831469612302545;
            4:       return 0.707106781186548;
            5:       return 0.555570233019602;
            6:       return 0.382683432365090;
            7:       return 0.195090322016128;
            default: return 0.0;
        endcase
    endfunction

    // Ck = round(0.5 * cos(k*pi/16) * 2^frac); the real-to-int cast rounds to nearest.
    function automatic int chen_const(input int k, input int frac);
        return int'(0.5 * cos_k16(k) * real'(longint'(1) << frac));
    endfunction

    // Round half up, arithmetic shift by frac, then clamp to a signed out_w range.
    function automatic logic signed [63:0] rnd_sat(input logic signed [63:0] v,
                                                   input int frac,
                                                   input int out_w);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (v + (64'sd1 <<< (frac - 1))) >>> frac;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (r > hi) return hi;
        if (r < lo) return lo;
        return r;
    endfunction

endpackage

// File: rtl/dct8_butterfly4.sv
// Stage-1 butterfly: s_i = x_i + x_(7-i), d_i = x_i - x_(7-i), widened by one bit.
// Purely combinational, no latency and no flow control of its own.
module dct8_butterfly4
    import dct8_chen_pkg::*;
#(
    parameter int W = 16
) (
    input  logic signed [W-1:0] x [NPT],
    output logic signed [W:0]   s [HALF],
    output logic signed [W:0]   d [HALF]
);

    for (genvar i = 0; i < HALF; i++) begin : g_bf
        assign s[i] = (W+1)'(x[i]) + (W+1)'(x[NPT-1-i]);
        assign d[i] = (W+1)'(x[i]) - (W+1)'(x[NPT-1-i]);
    end

endmodule

// File: rtl/dct8_chen_ts_core.sv
// Four-register pipelined 8-point DCT-II (Chen factorisation), one vector per cycle.
// Latency 4 cycles; a single advance enable stalls every stage while the output is held.
module dct8_chen_ts_core
    import dct8_chen_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int CONST_W = 16,
    parameter int FRAC    = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in0,
    input  logic signed [IN_W-1:0] in1,
    input  logic signed [IN_W-1:0] in2,
    input  logic signed [IN_W-1:0] in3,
    input  logic signed [IN_W-1:0] in4,
    input  logic signed [IN_W-1:0] in5,
    input  logic signed [IN_W-1:0] in6,
    input  logic signed [IN_W-1:0] in7,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [IN_W-1:0] out0,
    output logic signed [IN_W-1:0] out1,
    output logic signed [IN_W-1:0] out2,
    output logic signed [IN_W-1:0] out3,
    output logic signed [IN_W-1:0] out4,
    output logic signed [IN_W-1:0] out5,
    output logic signed [IN_W-1:0] out6,
    output logic signed [IN_W-1:0] out7
);

    localparam int S_W   = IN_W + 1;
    localparam int E_W   = IN_W + 2;
    localparam int PO_W  = S_W + CONST_W;
    localparam int P2_W  = E_W + CONST_W;
    localparam int PE_W  = E_W + 1 + CONST_W;
    // Holds every coefficient sum exactly; must stay within the 64-bit rescale helper.
    localparam int ACC_W = IN_W + CONST_W + 3;

    localparam int C1 = chen_const(1, FRAC);
    localparam int C2 = chen_const(2, FRAC);
    localparam int C3 = chen_const(3, FRAC);
    localparam int C4 = chen_const(4, FRAC);
    localparam int C5 = chen_const(5, FRAC);
    localparam int C6 = chen_const(6, FRAC);
    localparam int C7 = chen_const(7, FRAC);

    // Signed constant for odd output row r (X1, X3, X5, X7) and difference term d_i.
    function automatic int odd_coef(input int r, input int i);
        case (r * 4 + i)
            0:       return C1;
            1:       return C3;
            2:       return C5;
            3:       return C7;
            4:       return C3;
            5:       return -C7;
            6:       return -C1;
            7:       return -C5;
            8:       return C5;
            9:       return -C1;
            10:      return C7;
            11:      return C3;
            12:      return C7;
            13:      return -C5;
            14:      return C3;
            15:      return -C1;
            default: return 0;
        endcase
    endfunction

    logic signed [IN_W-1:0] x [NPT];
    logic signed [S_W-1:0]  s_c [HALF];
    logic signed [S_W-1:0]  d_c [HALF];
    logic signed [E_W-1:0]  e_c [HALF];
    logic signed [PE_W-1:0] ee_sum;
    logic signed [PE_W-1:0] ee_dif;
    logic signed [PE_W-1:0] pe_c [2];
    logic signed [P2_W-1:0] p2_c [4];
    logic signed [PO_W-1:0] po_c [HALF][HALF];
    logic signed [ACC_W-1:0] acc_c [NPT];
    logic signed [IN_W-1:0] y_c [NPT];

    logic [3:0]             vld;
    logic signed [S_W-1:0]  s_q [HALF];
    logic signed [S_W-1:0]  d_q [HALF];
    logic signed [E_W-1:0]  e_q [HALF];
    logic signed [S_W-1:0]  o_q [HALF];
    logic signed [PE_W-1:0] pe_q [2];
    logic signed [P2_W-1:0] p2_q [4];
    logic signed [PO_W-1:0] po_q [HALF][HALF];
    logic signed [IN_W-1:0] y_q [NPT];
    logic                   adv;

    assign x[0] = in0;
    assign x[1] = in1;
    assign x[2] = in2;
    assign x[3] = in3;
    assign x[4] = in4;
    assign x[5] = in5;
    assign x[6] = in6;
    assign x[7] = in7;

    dct8_butterfly4 #(.W(IN_W)) u_bf (
        .x (x),
        .s (s_c),
        .d (d_c)
    );

    // Bubbles are not squeezed out, so the only stall source is a held output.
    assign adv       = out_ready | ~vld[3];
    assign in_ready  = adv;
    assign out_valid = vld[3];

    always_comb begin
        e_c[0] = E_W'(s_q[0]) + E_W'(s_q[3]);
        e_c[3] = E_W'(s_q[0]) - E_W'(s_q[3]);
        e_c[1] = E_W'(s_q[1]) + E_W'(s_q[2]);
        e_c[2] = E_W'(s_q[1]) - E_W'(s_q[2]);
    end

    always_comb begin
        ee_sum  = PE_W'(e_q[0]) + PE_W'(e_q[1]);
        ee_dif  = PE_W'(e_q[0]) - PE_W'(e_q[1]);
        pe_c[0] = ee_sum * PE_W'(C4);
        pe_c[1] = ee_dif * PE_W'(C4);
        p2_c[0] = P2_W'(e_q[3]) * P2_W'(C2);
        p2_c[1] = P2_W'(e_q[2]) * P2_W'(C6);
        p2_c[2] = P2_W'(e_q[3]) * P2_W'(C6);
        p2_c[3] = P2_W'(e_q[2]) * P2_W'(C2);
        for (int r = 0; r < HALF; r++) begin
            for (int i = 0; i < HALF; i++) begin
                po_c[r][i] = PO_W'(o_q[i]) * PO_W'(odd_coef(r, i));
            end
        end
    end

    always_comb begin
        acc_c[0] = ACC_W'(pe_q[0]);
        acc_c[4] = ACC_W'(pe_q[1]);
        acc_c[2] = ACC_W'(p2_q[0]) + ACC_W'(p2_q[1]);
        acc_c[6] = ACC_W'(p2_q[2]) - ACC_W'(p2_q[3]);
        for (int r = 0; r < HALF; r++) begin
            acc_c[2*r+1] = '0;
            for (int i = 0; i < HALF; i++) begin
                acc_c[2*r+1] = acc_c[2*r+1] + ACC_W'(po_q[r][i]);
            end
        end
        for (int k = 0; k < NPT; k++) begin
            y_c[k] = IN_W'(rnd_sat(64'(acc_c[k]), FRAC, IN_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= '0;
            s_q  <= '{default: '0};
            d_q  <= '{default: '0};
            e_q  <= '{default: '0};
            o_q  <= '{default: '0};
            pe_q <= '{default: '0};
            p2_q <= '{default: '0};
            po_q <= '{default: '{default: '0}};
            y_q  <= '{default: '0};
        end else if (adv) begin
            vld  <= {vld[2:0], in_valid};
            s_q  <= s_c;
            d_q  <= d_c;
            e_q  <= e_c;
            o_q  <= d_q;
            pe_q <= pe_c;
            p2_q <= p2_c;
            po_q <= po_c;
            y_q  <= y_c;
        end
    end

    assign out0 = y_q[0];
    assign out1 = y_q[1];
    assign out2 = y_q[2];
    assign out3 = y_q[3];
    assign out4 = y_q[4];
    assign out5 = y_q[5];
    assign out6 = y_q[6];
    assign out7 = y_q[7];

endmodule

// File: tb/tb_dct8_chen_ts_core.sv
// Bench for dct8_chen_ts_core: directed spec vectors plus random streams checked
// against an integer reference DCT, including stall and asynchronous reset scenarios.
module tb_dct8_chen_ts_core;

    localparam int IN_W = 16;

    localparam int DV [4][8] = '{
        '{100, 100, 100, 100, 100, 100, 100, 100},
        '{1000, 0, 0, 0, 0, 0, 0, 0},
        '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767},
        '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768}
    };
    localparam int DE [4][8] = '{
        '{283, 0, 0, 0, 0, 0, 0, 0},
        '{354, 490, 462, 416, 354, 278, 191, 98},
        '{32767, 0, 0, 0, 0, 0, 0, 0},
        '{-32768, 0, 0, 0, 0, 0, 0, 0}
    };
    localparam int CK [8] = '{0, 2009, 1892, 1703, 1448, 1138, 784, 400};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready;
    logic out_valid;
    logic signed [IN_W-1:0] x [8];
    logic signed [IN_W-1:0] y [8];
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dct8_chen_ts_core #(.IN_W(IN_W), .CONST_W(16), .FRAC(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (x[0]),
        .in1       (x[1]),
        .in2       (x[2]),
        .in3       (x[3]),
        .in4       (x[4]),
        .in5       (x[5]),
        .in6       (x[6]),
        .in7       (x[7]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (y[0]),
        .out1      (y[1]),
        .out2      (y[2]),
        .out3      (y[3]),
        .out4      (y[4]),
        .out5      (y[5]),
        .out6      (y[6]),
        .out7      (y[7])
    );

    // Reference DCT straight from the transform equations, in wide integers.
    task automatic ref_dct(input int v[8], output int r[8]);
        longint s[4], d[4], a[8], t;
        longint e0, e1, e2, e3;
        for (int i = 0; i < 4; i++) begin
            s[i] = longint'(v[i]) + longint'(v[7-i]);
            d[i] = longint'(v[i]) - longint'(v[7-i]);
        end
        e0 = s[0] + s[3]; e3 = s[0] - s[3];
        e1 = s[1] + s[2]; e2 = s[1] - s[2];
        a[0] = CK[4] * (e0 + e1);
        a[4] = CK[4] * (e0 - e1);
        a[2] = CK[2] * e3 + CK[6] * e2;
        a[6] = CK[6] * e3 - CK[2] * e2;
        a[1] = CK[1] * d[0] + CK[3] * d[1] + CK[5] * d[2] + CK[7] * d[3];
        a[3] = CK[3] * d[0] - CK[7] * d[1] - CK[1] * d[2] - CK[5] * d[3];
        a[5] = CK[5] * d[0] - CK[1] * d[1] + CK[7] * d[2] + CK[3] * d[3];
        a[7] = CK[7] * d[0] - CK[5] * d[1] + CK[3] * d[2] - CK[1] * d[3];
        for (int k = 0; k < 8; k++) begin
            t = (a[k] + 2048) >>> 12;
            if (t > 32767) t = 32767;
            if (t < -32768) t = -32768;
            r[k] = int'(t);
        end
    endtask

    task automatic new_vec(output int v[8]);
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) v[i] = int'($signed(16'($urandom())));
            else v[i] = int'($signed(12'($urandom())));
        end
    endtask

    task automatic drive_vec(input int v[8]);
        for (int i = 0; i < 8; i++) x[i] = 16'(v[i]);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (y[k] !== 16'sd0) begin errors++; $display("FAIL reset_out%0d: got %0d expected 0", k, y[k]); end
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int acc;
        int waited;
        int v[8];
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 8; i++) v[i] = DV[t][i];
            drive_vec(v);
            in_valid = 1'b1;
            acc = cyc;
            @(posedge clk); #1;
            in_valid = 1'b0;
            waited = 1;
            while (out_valid !== 1'b1 && waited < 12) begin
                @(posedge clk); #1;
                waited++;
            end
            checks++;
            if (cyc - acc != 4) begin errors++; $display("FAIL directed%0d_latency: got %0d expected 4", t, cyc - acc); end
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (int'(y[k]) !== DE[t][k]) begin
                    errors++;
                    $display("FAIL directed%0d_X%0d: got %0d expected %0d", t, k, y[k], DE[t][k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int vin[8], r[8];
        int exp_q[$];
        int acc_q[$];
        int sent = 0, got = 0, it = 0, acc, e;
        out_ready = 1'b1;
        new_vec(vin);
        while (got < 12 && it < 60) begin
            @(posedge clk); #1;
            it++;
            in_valid = (sent < 12);
            drive_vec(vin);
            #1;
            if (out_valid === 1'b1) begin
                checks++;
                if (acc_q.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected: got out_valid=1 expected 0");
                end else begin
                    got++;
                    acc = acc_q.pop_front();
                    if (cyc - acc != 4) begin errors++; $display("FAIL b2b_latency: got %0d expected 4", cyc - acc); end
                    for (int k = 0; k < 8; k++) begin
                        e = exp_q.pop_front();
                        checks++;
                        if (int'(y[k]) !== e) begin errors++; $display("FAIL b2b_X%0d: got %0d expected %0d", k, y[k], e); end
                    end
                end
            end
            if (in_valid && in_ready) begin
                ref_dct(vin, r);
                for (int k = 0; k < 8; k++) exp_q.push_back(r[k]);
                acc_q.push_back(cyc);
                sent++;
                new_vec(vin);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got != 12) begin errors++; $display("FAIL b2b_count: got %0d expected 12", got); end
    endtask

    task automatic test_stall();
        int vin[8], r[8], prev[8];
        int exp_q[$];
        int sent = 0, got = 0, it = 0, e;
        bit held = 0;
        new_vec(vin);
        while (got < 14 && it < 120) begin
            @(posedge clk); #1;
            out_ready = !(it >= 6 && it < 12);
            it++;
            in_valid = (sent < 14);
            drive_vec(vin);
            #1;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_hold: got %b expected 1", out_valid); end
                for (int k = 0; k < 8; k++) begin
                    checks++;
                    if (int'(y[k]) !== prev[k]) begin errors++; $display("FAIL stall_hold_X%0d: got %0d expected %0d", k, y[k], prev[k]); end
                end
            end
            if (out_valid === 1'b1 && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stall_unexpected: got out_valid=1 expected 0");
                end else begin
                    got++;
                    for (int k = 0; k < 8; k++) begin
                        e = exp_q.pop_front();
                        checks++;
                        if (int'(y[k]) !== e) begin errors++; $display("FAIL stall_X%0d: got %0d expected %0d", k, y[k], e); end
                    end
                end
            end
            held = (out_valid === 1'b1) && !out_ready;
            for (int k = 0; k < 8; k++) prev[k] = int'(y[k]);
            if (in_valid && in_ready) begin
                ref_dct(vin, r);
                for (int k = 0; k < 8; k++) exp_q.push_back(r[k]);
                sent++;
                new_vec(vin);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 14 || exp_q.size() != 0) begin
            errors++; $display("FAIL stall_count: got %0d outputs, %0d left expected 14, 0", got, exp_q.size() / 8);
        end
    endtask

    task automatic test_async_reset();
        int vin[8], r[8];
        int acc;
        out_ready = 1'b1;
        for (int it = 0; it < 6; it++) begin
            @(posedge clk); #1;
            new_vec(vin);
            drive_vec(vin);
            in_valid = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b expected 1", in_ready); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (y[k] !== 16'sd0) begin errors++; $display("FAIL arst_out%0d: got %0d expected 0", k, y[k]); end
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        new_vec(vin);
        drive_vec(vin);
        ref_dct(vin, r);
        in_valid = 1'b1;
        acc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (cyc - acc <= 5) begin
            checks++;
            if (out_valid !== ((cyc - acc) == 4)) begin
                errors++; $display("FAIL arst_post_valid_c%0d: got %b expected %b", cyc - acc, out_valid, (cyc - acc) == 4);
            end
            if (cyc - acc == 4) begin
                for (int k = 0; k < 8; k++) begin
                    checks++;
                    if (int'(y[k]) !== r[k]) begin errors++; $display("FAIL arst_post_X%0d: got %0d expected %0d", k, y[k], r[k]); end
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) x[i] = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
